bcd_serial_addsub: RTL and testbench
====================================

BCD_SERIAL_ADDSUB -- requirements
Module: bcd_serial_addsub

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of BCD digits per operand; legal range is 1..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an operand set is presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have ports a and b, inputs, 4*DIGITS bits each: packed BCD operands, digit 0 in bits [3:0].
REQ-007 The block SHALL have port sub, input, 1 bit: 0 = add, 1 = subtract (a - b).
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in to digit 0 in add mode; ignored in subtract mode.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is available.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port sum, output, 4*DIGITS bits: packed BCD result.
REQ-012 The block SHALL have port cout, output, 1 bit: add mode, decimal carry-out; subtract mode, 1 = no borrow (a >= b).
REQ-013 The block SHALL have port err, output, 1 bit: at least one digit of the accepted a or b was greater than 9.

Function
REQ-014 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 The block SHALL assert in_ready only in IDLE; operands are accepted on the edge where in_valid & in_ready = 1.
REQ-016 On acceptance, the block SHALL register a, b, sub and cin, clear the digit index to 0, and enter RUN.
REQ-017 In RUN, the block SHALL process one digit per cycle, from digit 0 upward: z = a_i + b'_i + c, where b'_i = b_i (add) or 9 - b_i (subtract).
REQ-018 The block SHALL take the initial c for digit 0 as cin (add) or 1 (subtract).
REQ-019 If z > 9, the block SHALL store s_i = (z + 6) mod 16 and set the next c to 1; otherwise it SHALL store s_i = z and set the next c to 0.
REQ-020 After the digit at index DIGITS-1, the block SHALL load cout with the final carry and enter DONE; RUN lasts exactly DIGITS cycles.
REQ-021 The block SHALL assert out_valid in DONE only, first DIGITS+1 cycles after the acceptance edge.
REQ-022 sum, cout and err SHALL hold stable while out_valid = 1.
REQ-023 DONE SHALL hold until out_valid & out_ready = 1 on an edge, then go to IDLE; there are no back-to-back transfers, and throughput is one operation per DIGITS+2 cycles minimum.
REQ-024 In subtract mode with a < b, the block SHALL output sum as the ten's complement 10^DIGITS - (b - a) with cout = 0.
REQ-025 err SHALL be the OR over all accepted digits (a_i > 9 or b_i > 9), fixed at acceptance; the computation still proceeds per REQ-017..019.
REQ-026 For a digit value > 9 in subtract mode, the block SHALL truncate 9 - b_i to 4 bits.
REQ-027 The block SHALL ignore in_valid in RUN and DONE, and SHALL ignore out_ready outside DONE.

Reset
REQ-028 While rst_n = 0, the block SHALL be in IDLE with in_ready = 1, out_valid = 0, sum = 0, cout = 0, err = 0, and the digit index and carry at 0.
REQ-029 Assertion of rst_n SHALL take effect immediately, regardless of clk.
REQ-030 Reset in RUN or DONE SHALL abort the operation with no partial result or out_valid pulse; the first edge after release can accept operands.

Verification (DIGITS = 4)
REQ-031 The bench SHALL apply add a=1234, b=8766, cin=0 and check sum=0000, cout=1, err=0, with out_valid 5 cycles after acceptance.
REQ-032 The bench SHALL apply add a=0999, b=0000, cin=1 and check sum=1000, cout=0, exercising the carry ripple through three digits.
REQ-033 The bench SHALL apply subtract 5000-1234 and check sum=3766, cout=1; it SHALL then apply subtract 1234-5000 and check sum=6234, cout=0.
REQ-034 The bench SHALL apply a=0x00A0, b=0x0001, add, and check err=1 and out_valid still raised at the normal latency.
REQ-035 The bench SHALL hold out_ready=0 for 10 cycles in DONE and check that out_valid, sum and cout stay stable, in_ready=0, and a new in_valid is ignored.
REQ-036 The bench SHALL drive rst_n low in the 2nd RUN cycle and check that outputs are zero immediately; after release, 1234+8766 completes correctly.

Source files
------------

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor.
// Operands are taken with a valid/ready handshake. One decimal digit is
// processed per cycle, digit 0 first. The result is held under a
// valid/ready handshake until the consumer takes it.
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  sub,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic             sub_reg;
    logic             carry;
    logic [IDX_W-1:0] idx;

    logic [3:0]       a_dig;
    logic [3:0]       b_dig;
    logic [3:0]       b_eff;
    logic [4:0]       z;
    logic [4:0]       z_adj;
    logic [3:0]       s_dig;
    logic             c_next;
    logic [W+3:0]     sum_shift;
    logic             in_err;

    // The operand registers shift right each RUN cycle, so the current digit is always in the low nibble.
    always_comb begin
        a_dig     = a_reg[3:0];
        b_dig     = b_reg[3:0];
        b_eff     = sub_reg ? (4'd9 - b_dig) : b_dig;
        z         = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry};
        z_adj     = z + 5'd6;
        s_dig     = z[3:0];
        c_next    = 1'b0;
        if (z > 5'd9) begin
            s_dig  = z_adj[3:0];
            c_next = 1'b1;
        end
        sum_shift = {s_dig, sum};
    end

    // Flag any non-decimal digit in the operands being presented.
    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
                in_err = 1'b1;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Handshake FSM and datapath; result digits shift in from the top so digit 0 lands at [3:0] after the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            sub_reg <= 1'b0;
            carry   <= 1'b0;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        sub_reg <= sub;
                        carry   <= sub ? 1'b1 : cin;
                        idx     <= '0;
                        sum     <= '0;
                        cout    <= 1'b0;
                        err     <= in_err;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_reg <= a_reg >> 4;
                    b_reg <= b_reg >> 4;
                    sum   <= sum_shift[W+3:4];
                    carry <= c_next;
                    if (idx == LAST_IDX) begin
                        cout  <= c_next;
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Testbench for bcd_serial_addsub with DIGITS = 4.
// Directed cases plus randomized operations compared against a decimal
// reference model; includes a result-hold test and a mid-operation reset.
module tb_bcd_serial_addsub;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    int check_count;
    int error_count;

    bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int bcdToInt(input logic [W-1:0] v);
        int r;
        r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            r = r * 10 + int'(v[4*i +: 4]);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] intToBcd(input int n);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Decimal integer arithmetic for legal operands; the digit recurrence is only
    // used when an operand holds a non-decimal digit and the result is defined digit by digit.
    task automatic refModel(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv, input logic cv,
                            output logic [W-1:0] exp_sum, output logic exp_cout, output logic exp_err);
        int ai, bi, total, c, z, bd, modulus;
        exp_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) exp_err = 1'b1;
        end
        modulus = 1;
        for (int i = 0; i < DIGITS; i++) modulus = modulus * 10;
        if (!exp_err) begin
            ai = bcdToInt(av);
            bi = bcdToInt(bv);
            if (!sv) begin
                total    = ai + bi + int'(cv);
                exp_sum  = intToBcd(total % modulus);
                exp_cout = (total >= modulus);
            end else if (ai >= bi) begin
                exp_sum  = intToBcd(ai - bi);
                exp_cout = 1'b1;
            end else begin
                exp_sum  = intToBcd(modulus - (bi - ai));
                exp_cout = 1'b0;
            end
        end else begin
            exp_sum = '0;
            c = sv ? 1 : int'(cv);
            for (int i = 0; i < DIGITS; i++) begin
                bd = sv ? ((9 - int'(bv[4*i +: 4])) & 15) : int'(bv[4*i +: 4]);
                z  = int'(av[4*i +: 4]) + bd + c;
                if (z > 9) begin
                    exp_sum[4*i +: 4] = 4'((z + 6) % 16);
                    c = 1;
                end else begin
                    exp_sum[4*i +: 4] = 4'(z);
                    c = 0;
                end
            end
            exp_cout = (c != 0);
        end
    endtask

    // Run one operation from acceptance to release; during the hold, new operands are offered and must be ignored.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv, input logic cv,
                                 input int hold_cycles);
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_err;
        int           cycles;
        refModel(av, bv, sv, cv, exp_sum, exp_cout, exp_err);
        a        = av;
        b        = bv;
        sub      = sv;
        cin      = cv;
        in_valid = 1'b1;
        checkOutput("in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // out_valid rises on the DIGITS-th edge after acceptance (5th edge counting the acceptance edge).
        cycles = 0;
        while (!out_valid && cycles < 50) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("latency", 64'(cycles), 64'(DIGITS));
        checkOutput("out_valid", 64'(out_valid), 64'd1);
        checkOutput("sum", 64'(sum), 64'(exp_sum));
        checkOutput("cout", 64'(cout), 64'(exp_cout));
        checkOutput("err", 64'(err), 64'(exp_err));
        for (int i = 0; i < hold_cycles; i++) begin
            a        = W'($urandom);
            b        = W'($urandom);
            sub      = 1'($urandom);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("hold_out_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_sum", 64'(sum), 64'(exp_sum));
            checkOutput("hold_cout", 64'(cout), 64'(exp_cout));
            checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("release_out_valid", 64'(out_valid), 64'd0);
        checkOutput("release_in_ready", 64'(in_ready), 64'd1);
    endtask

    // Random operand with mostly decimal digits and an occasional illegal one.
    function automatic logic [W-1:0] randomOperand();
        logic [W-1:0] v;
        for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 7) == 0) v[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    // Main sequence
    initial begin
        check_count = 0;
        error_count = 0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a           = '0;
        b           = '0;
        sub         = 1'b0;
        cin         = 1'b0;
        rst_n       = 1'b1;
        #1;
        rst_n = 1'b0;
        #3;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_sum", 64'(sum), 64'd0);
        checkOutput("rst_cout", 64'(cout), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] directed cases");
        applyStimulus(16'h1234, 16'h8766, 1'b0, 1'b0, 0);
        applyStimulus(16'h0999, 16'h0000, 1'b0, 1'b1, 0);
        applyStimulus(16'h5000, 16'h1234, 1'b1, 1'b0, 0);
        applyStimulus(16'h1234, 16'h5000, 1'b1, 1'b0, 0);
        applyStimulus(16'h00A0, 16'h0001, 1'b0, 1'b0, 0);
        applyStimulus(16'h4321, 16'h1111, 1'b0, 1'b0, 10);

        $display("[TB] reset during RUN");
        a        = 16'h1111;
        b        = 16'h2222;
        sub      = 1'b0;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("partial_sum", 64'(sum), 64'h3000);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_sum", 64'(sum), 64'd0);
        checkOutput("abort_cout", 64'(cout), 64'd0);
        checkOutput("abort_err", 64'(err), 64'd0);
        checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkOutput("in_reset_out_valid", 64'(out_valid), 64'd0);
        end
        rst_n = 1'b1;
        applyStimulus(16'h1234, 16'h8766, 1'b0, 1'b0, 0);

        $display("[TB] random cases");
        for (int n = 0; n < 40; n++) begin
            applyStimulus(randomOperand(), randomOperand(), 1'($urandom), 1'($urandom),
                          int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
